// File: rtl/syscall_ex_unit.sv
// EX-stage syscall unit: halts the pipeline on the halt syscall, latches
// printed $a0 to the board display, and keeps cycle/syscall counters.
module syscall_ex_unit #(
  parameter logic [31:0] HALT_CODE  = 32'd10,
  parameter logic [31:0] PRINT_CODE = 32'd34,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             syscall_valid,
  input  logic [31:0]      v0_data,
  input  logic [31:0]      a0_data,
  input  logic             go,
  output logic             halt_ex,
  output logic             pc_en,
  output logic             halted,
  output logic [31:0]      display_data,
  output logic             display_valid,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] syscall_count
);

  typedef enum logic [1:0] {
    RUN,
    HALT,
    RELEASE
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   go_q;
  logic   accept;
  logic   halt_now;
  logic   print_now;
  logic   go_rise;

  assign accept    = syscall_valid & (state == RUN);
  assign halt_now  = accept & (v0_data == HALT_CODE);
  assign print_now = accept & (v0_data == PRINT_CODE);
  assign go_rise   = go & ~go_q;

  // halt_ex re-injects the halt syscall every cycle we sit in HALT
  assign halted  = (state == HALT);
  assign halt_ex = halt_now | halted;
  assign pc_en   = ~halt_ex;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (halt_now) state_nxt = HALT;
      end
      HALT: begin
        if (go_rise) state_nxt = RELEASE;
      end
      RELEASE: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      go_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      go_q  <= go;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_data  <= '0;
      display_valid <= 1'b0;
    end else begin
      display_valid <= print_now;
      if (print_now) display_data <= a0_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count   <= '0;
      syscall_count <= '0;
    end else begin
      if (state != HALT) cycle_count <= cycle_count + 1'b1;
      if (accept) syscall_count <= syscall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_syscall_ex_unit.sv
// Directed bench for syscall_ex_unit; display pulses are checked through
// an expected-value queue drained by a separate monitor.
module tb_syscall_ex_unit;

  logic        clk;
  logic        rst;
  logic        syscall_valid;
  logic [31:0] v0_data;
  logic [31:0] a0_data;
  logic        go;
  logic        halt_ex;
  logic        pc_en;
  logic        halted;
  logic [31:0] display_data;
  logic        display_valid;
  logic [31:0] cycle_count;
  logic [31:0] syscall_count;

  logic        s_halt_ex;
  logic        s_pc_en;
  logic        s_halted;
  logic [31:0] s_display_data;
  logic        s_display_valid;
  logic [3:0]  s_cycle_count;
  logic [3:0]  s_syscall_count;

  int checks   = 0;
  int failures = 0;
  int ec       = 0;
  logic [31:0] disp_q[$];

  syscall_ex_unit dut (
    .clk(clk),
    .rst(rst),
    .syscall_valid(syscall_valid),
    .v0_data(v0_data),
    .a0_data(a0_data),
    .go(go),
    .halt_ex(halt_ex),
    .pc_en(pc_en),
    .halted(halted),
    .display_data(display_data),
    .display_valid(display_valid),
    .cycle_count(cycle_count),
    .syscall_count(syscall_count)
  );

  syscall_ex_unit #(.CNT_W(4)) dut_small (
    .clk(clk),
    .rst(rst),
    .syscall_valid(syscall_valid),
    .v0_data(v0_data),
    .a0_data(a0_data),
    .go(go),
    .halt_ex(s_halt_ex),
    .pc_en(s_pc_en),
    .halted(s_halted),
    .display_data(s_display_data),
    .display_valid(s_display_valid),
    .cycle_count(s_cycle_count),
    .syscall_count(s_syscall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input bit cnt);
    @(posedge clk);
    #1;
    if (cnt) ec++;
  endtask

  always @(negedge clk) begin
    if (!rst && display_valid) begin
      checks++;
      if (disp_q.size() == 0) begin
        failures++;
        $display("FAIL disp_unexpected actual=%h required=none",
                 display_data);
      end else begin
        logic [31:0] e;
        e = disp_q.pop_front();
        if (display_data !== e) begin
          failures++;
          $display("FAIL disp_data actual=%h required=%h",
                   display_data, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    syscall_valid = 1'b0;
    v0_data = '0;
    a0_data = '0;
    go = 1'b0;
    #12;
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_halt_ex", {31'd0, halt_ex}, 32'd0);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
    chk("rst_disp", display_data, 32'd0);
    chk("rst_dv", {31'd0, display_valid}, 32'd0);
    chk("rst_cyc", cycle_count, 32'd0);
    chk("rst_sys", syscall_count, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    repeat (17) tick(1);
    chk("wrap_small", {28'd0, s_cycle_count}, 32'd1);
    chk("cyc_17", cycle_count, 32'd17);

    syscall_valid = 1'b1;
    v0_data = 32'd34;
    a0_data = 32'hDEADBEEF;
    disp_q.push_back(32'hDEADBEEF);
    #1 chk("print_pc_en", {31'd0, pc_en}, 32'd1);
    tick(1);
    syscall_valid = 1'b0;
    chk("print_dv", {31'd0, display_valid}, 32'd1);
    chk("print_data", display_data, 32'hDEADBEEF);
    chk("print_sys", syscall_count, 32'd1);
    tick(1);
    chk("print_dv_off", {31'd0, display_valid}, 32'd0);

    syscall_valid = 1'b1;
    v0_data = 32'd10;
    #1;
    chk("halt_comb_ex", {31'd0, halt_ex}, 32'd1);
    chk("halt_comb_pc", {31'd0, pc_en}, 32'd0);
    chk("halt_comb_st", {31'd0, halted}, 32'd0);
    tick(1);
    chk("halt_st", {31'd0, halted}, 32'd1);
    repeat (20) tick(0);
    chk("halt_cyc", cycle_count, ec);
    chk("halt_sys", syscall_count, 32'd2);
    chk("halt_pc", {31'd0, pc_en}, 32'd0);

    go = 1'b1;
    tick(0);
    chk("rel_halted", {31'd0, halted}, 32'd0);
    chk("rel_halt_ex", {31'd0, halt_ex}, 32'd0);
    chk("rel_pc_en", {31'd0, pc_en}, 32'd1);
    chk("rel_sys", syscall_count, 32'd2);
    tick(1);
    chk("run2_halt_ex", {31'd0, halt_ex}, 32'd1);
    chk("run2_halted", {31'd0, halted}, 32'd0);
    tick(1);
    chk("halt2_sys", syscall_count, 32'd3);
    repeat (10) tick(0);
    chk("halt2_hold", {31'd0, halted}, 32'd1);

    go = 1'b0;
    tick(0);
    go = 1'b1;
    tick(0);
    syscall_valid = 1'b0;
    chk("rel2_pc_en", {31'd0, pc_en}, 32'd1);
    tick(1);
    chk("run3_halted", {31'd0, halted}, 32'd0);
    chk("run3_pc_en", {31'd0, pc_en}, 32'd1);

    go = 1'b0;
    tick(1);
    go = 1'b1;
    syscall_valid = 1'b1;
    v0_data = 32'd10;
    tick(1);
    syscall_valid = 1'b0;
    chk("same_halt", {31'd0, halted}, 32'd1);
    repeat (3) tick(0);
    chk("same_norel", {31'd0, halted}, 32'd1);
    chk("same_sys", syscall_count, 32'd4);
    go = 1'b0;
    tick(0);
    go = 1'b1;
    tick(0);
    tick(1);
    chk("run4_halted", {31'd0, halted}, 32'd0);

    syscall_valid = 1'b1;
    v0_data = 32'd5;
    a0_data = 32'd123;
    tick(1);
    syscall_valid = 1'b0;
    chk("other_sys", syscall_count, 32'd5);
    chk("other_disp", display_data, 32'hDEADBEEF);
    chk("other_dv", {31'd0, display_valid}, 32'd0);

    syscall_valid = 1'b1;
    v0_data = 32'h1000_000A;
    #1 chk("upper_halt_ex", {31'd0, halt_ex}, 32'd0);
    tick(1);
    syscall_valid = 1'b0;
    chk("upper_halted", {31'd0, halted}, 32'd0);
    chk("upper_sys", syscall_count, 32'd6);
    chk("cyc_total", cycle_count, ec);

    syscall_valid = 1'b1;
    v0_data = 32'd10;
    tick(1);
    syscall_valid = 1'b0;
    chk("h3_halted", {31'd0, halted}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_pc_en", {31'd0, pc_en}, 32'd1);
    chk("arst_cyc", cycle_count, 32'd0);
    chk("arst_sys", syscall_count, 32'd0);
    chk("arst_disp", display_data, 32'd0);
    chk("arst_s_pc_en", {31'd0, s_pc_en}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("disp_q_empty", disp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/syscall_ex_unit.md
Name: syscall_ex_unit

Overview:
- EX-stage consumer of the ID/EX pipeline register's syscall fields (syscall flag, $v0 operand, $a0 operand).
- Decodes syscalls: v0=HALT_CODE freezes the pipeline; v0=PRINT_CODE latches $a0 to the display.
- Drives halt_ex back into the ID/EX register so the halting syscall is re-injected every cycle while halted.
- Resumes on a go edge; keeps cycle and syscall counters for the board display.

Parameters:
HALT_CODE, 10, $v0 value that halts the pipeline
PRINT_CODE, 34, $v0 value that latches $a0 to display_data
CNT_W, 32, width of cycle_count and syscall_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
syscall_valid  input  1  SyscallSrc from ID/EX: the instruction in EX is a syscall
v0_data  input  32  read_data1 from ID/EX ($v0)
a0_data  input  32  read_data2 from ID/EX ($a0)
go  input  1  resume request, synchronous level; only its rising edge acts
halt_ex  output  1  to ID/EX: force a syscall with v0=HALT_CODE
pc_en  output  1  PC / IF-ID write enable; 0 freezes fetch
halted  output  1  state==HALT
display_data  output  32  last printed $a0
display_valid  output  1  one-cycle pulse when display_data is updated
cycle_count  output  CNT_W  count of non-halted cycles
syscall_count  output  CNT_W  count of accepted syscalls

Behaviour:
- Reset: async on rst high.
  - state=RUN; go_q=0; display_data=0; display_valid=0; cycle_count=0; syscall_count=0.
  - Resulting outputs: halted=0, halt_ex=0, pc_en=1.
  - Reset asserted while in HALT or RELEASE returns to RUN immediately.
- FSM states: RUN, HALT, RELEASE.
- Signal definitions:
  - accept = syscall_valid & (state==RUN).
  - halt_now = accept & (v0_data==HALT_CODE).
  - go_rise = go & ~go_q; go_q is registered every cycle.
- Outputs (combinational from state and inputs, zero latency):
  - halt_ex = halt_now | (state==HALT).
  - pc_en = ~halt_ex.
  - halted = (state==HALT).
- Transitions:
  - RUN -> HALT when halt_now. Fetch freezes in the same cycle, and ID/EX captures the injected halt syscall at that edge.
  - HALT -> RELEASE on go_rise; otherwise stay in HALT.
  - RELEASE -> RUN unconditionally after 1 cycle.
- RELEASE cycle:
  - halt_ex=0 and pc_en=1, so the pipeline advances past the injected syscall.
  - The syscall_valid/v0=HALT_CODE still present in EX during this cycle is ignored (accept=0).
  - One halt therefore costs exactly one re-injected bubble.
- go:
  - A held-high go produces one release only; another go_rise is needed after the next halt.
  - go_rise in RUN or RELEASE is ignored.
  - go_rise in the same cycle as halt_now is ignored; the unit still enters HALT.
- Print: accept & (v0_data==PRINT_CODE) -> display_data<=a0_data and display_valid<=1 at the next edge; otherwise display_valid<=0.
- syscall_count:
  - Increments on every accept, for any v0 value, including halt and print.
  - Other v0 values: counted only, no other effect.
  - Syscalls in HALT and RELEASE are not counted.
- cycle_count: increments each cycle state!=HALT (RUN and RELEASE).
- Counter wrap: both counters wrap modulo 2^CNT_W with no saturation or flag.
- Equality compares use full 32-bit v0_data; upper bits must match.

Test Plan:
- rst pulse mid-run -> all outputs at reset values asynchronously, before the next clk edge; pc_en=1.
- syscall_valid=1, v0=34, a0=0xDEADBEEF in RUN -> next cycle display_data=0xDEADBEEF, display_valid=1 for exactly 1 cycle, syscall_count=1, pc_en stays 1.
- syscall_valid=1, v0=10 -> same cycle halt_ex=1, pc_en=0; next cycle halted=1; hold 20 cycles with syscall_valid=1, v0=10 -> cycle_count frozen, syscall_count +1 total.
- In HALT, raise go and hold 10 cycles -> exactly one RELEASE cycle (pc_en=1, halt_ex=0), then RUN; a second v0=10 syscall halts again and stays halted despite go still high.
- go rising in the same cycle as v0=10 syscall -> HALT entered, no release; syscall v0=5 -> syscall_count+1, display unchanged.
- CNT_W=4, run 17 non-halted cycles from reset -> cycle_count=1 (wrapped); assert rst during HALT -> RUN, pc_en=1 immediately.
